// File: rtl/cdda_sector_feeder.sv
// CD-DA sector feeder: requests host sectors over an LBA range and packs 16-bit words into stereo frames.
// Optional build macro CDDA_BYTESWAP_EN enables per-word byte swapping under BYTESWAP.
module cdda_sector_feeder #(
    parameter int SECTOR_WORDS = 1176,
    parameter int LBA_WIDTH    = 24
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 play_start_i,
    input  logic [LBA_WIDTH-1:0] start_lba_i,
    input  logic [LBA_WIDTH-1:0] end_lba_i,
    input  logic                 stop_i,
    input  logic                 pause_i,
    input  logic                 byteswap_i,
    input  logic                 cdda_req_i,
    output logic                 cdda_wr_o,
    output logic [31:0]          cdda_data_o,
    output logic                 host_req_o,
    output logic [LBA_WIDTH-1:0] host_lba_o,
    input  logic                 host_ack_i,
    input  logic                 host_wr_i,
    input  logic [15:0]          host_data_i,
    output logic                 playing_o,
    output logic [LBA_WIDTH-1:0] cur_lba_o,
    output logic                 done_o
);

    localparam int CW = $clog2(SECTOR_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_XFER,
        S_DRAIN
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [15:0]          half_q;
    logic [LBA_WIDTH-1:0] start_q;
    logic [LBA_WIDTH-1:0] end_q;
    logic [LBA_WIDTH-1:0] cur_q;
    logic [LBA_WIDTH-1:0] hlba_q;
    logic                 restart_q;
    logic                 cdda_wr_q;
    logic [31:0]          cdda_data_q;
    logic                 host_req_q;
    logic                 playing_q;
    logic                 done_q;

    logic [15:0]          word;
    logic                 last;
    logic [LBA_WIDTH-1:0] nxt_start;
    logic [LBA_WIDTH-1:0] nxt_end;
    logic                 empty;
    state_t               rs_state;

`ifdef CDDA_BYTESWAP_EN
    assign word = byteswap_i ? {host_data_i[7:0], host_data_i[15:8]} : host_data_i;
`else
    logic unused_bs;
    assign unused_bs = byteswap_i;
    assign word      = host_data_i;
`endif

    // A restart takes a range presented this cycle, else the one latched earlier
    assign last      = (cnt_q == CW'(SECTOR_WORDS - 1));
    assign nxt_start = play_start_i ? start_lba_i : start_q;
    assign nxt_end   = play_start_i ? end_lba_i : end_q;
    assign empty     = (nxt_start >= nxt_end);
    assign rs_state  = empty ? S_IDLE : S_WAIT;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            half_q      <= '0;
            start_q     <= '0;
            end_q       <= '0;
            cur_q       <= '0;
            hlba_q      <= '0;
            restart_q   <= 1'b0;
            cdda_wr_q   <= 1'b0;
            cdda_data_q <= '0;
            host_req_q  <= 1'b0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cdda_wr_q <= 1'b0;
            done_q    <= 1'b0;
            if (play_start_i) begin
                start_q <= start_lba_i;
                end_q   <= end_lba_i;
            end
            case (state_q)
                S_IDLE: begin
                    if (play_start_i) begin
                        cur_q     <= start_lba_i;
                        state_q   <= rs_state;
                        playing_q <= ~empty;
                        done_q    <= empty;
                    end
                end
                S_WAIT: begin
                    if (play_start_i) begin
                        cur_q     <= start_lba_i;
                        state_q   <= rs_state;
                        playing_q <= ~empty;
                        done_q    <= empty;
                    end else if (stop_i) begin
                        playing_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (cur_q == end_q) begin
                        done_q    <= 1'b1;
                        playing_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (cdda_req_i && !pause_i) begin
                        host_req_q <= 1'b1;
                        hlba_q     <= cur_q;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (play_start_i) begin
                        host_req_q <= 1'b0;
                        cur_q      <= start_lba_i;
                        state_q    <= rs_state;
                        playing_q  <= ~empty;
                        done_q     <= empty;
                    end else if (stop_i) begin
                        host_req_q <= 1'b0;
                        playing_q  <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (host_ack_i) begin
                        host_req_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (host_wr_i) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (!cnt_q[0]) half_q <= word;
                    end
                    if (play_start_i || stop_i) begin
                        restart_q <= play_start_i;
                        if (host_wr_i && last) begin
                            restart_q <= 1'b0;
                            if (play_start_i) begin
                                cur_q     <= start_lba_i;
                                state_q   <= rs_state;
                                playing_q <= ~empty;
                                done_q    <= empty;
                            end else begin
                                playing_q <= 1'b0;
                                state_q   <= S_IDLE;
                            end
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (host_wr_i) begin
                        if (cnt_q[0]) begin
                            cdda_data_q <= {word, half_q};
                            cdda_wr_q   <= 1'b1;
                        end
                        if (last) begin
                            cur_q   <= cur_q + LBA_WIDTH'(1);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (play_start_i) restart_q <= 1'b1;
                    else if (stop_i) restart_q <= 1'b0;
                    if (host_wr_i) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (last) begin
                            restart_q <= 1'b0;
                            if (play_start_i || (restart_q && !stop_i)) begin
                                cur_q     <= nxt_start;
                                state_q   <= rs_state;
                                playing_q <= ~empty;
                                done_q    <= empty;
                            end else begin
                                playing_q <= 1'b0;
                                state_q   <= S_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cdda_wr_o   = cdda_wr_q;
    assign cdda_data_o = cdda_data_q;
    assign host_req_o  = host_req_q;
    assign host_lba_o  = hlba_q;
    assign playing_o   = playing_q;
    assign cur_lba_o   = cur_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_cdda_sector_feeder.sv
// Testbench for cdda_sector_feeder: acts as host disk interface and FIFO, checks frames against a model.
// Expected byte order follows the CDDA_BYTESWAP_EN build macro.
module tb_cdda_sector_feeder;

    localparam int SW = 1176;
    localparam int LW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          play_start = 1'b0;
    logic [LW-1:0] start_lba = '0;
    logic [LW-1:0] end_lba = '0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          byteswap = 1'b0;
    logic          cdda_req = 1'b0;
    logic          cdda_wr;
    logic [31:0]   cdda_data;
    logic          host_req;
    logic [LW-1:0] host_lba;
    logic          host_ack = 1'b0;
    logic          host_wr = 1'b0;
    logic [15:0]   host_data = '0;
    logic          playing;
    logic [LW-1:0] cur_lba;
    logic          done;

    always #5 clk = ~clk;

    cdda_sector_feeder #(.SECTOR_WORDS(SW), .LBA_WIDTH(LW)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .play_start_i (play_start),
        .start_lba_i  (start_lba),
        .end_lba_i    (end_lba),
        .stop_i       (stop),
        .pause_i      (pause),
        .byteswap_i   (byteswap),
        .cdda_req_i   (cdda_req),
        .cdda_wr_o    (cdda_wr),
        .cdda_data_o  (cdda_data),
        .host_req_o   (host_req),
        .host_lba_o   (host_lba),
        .host_ack_i   (host_ack),
        .host_wr_i    (host_wr),
        .host_data_i  (host_data),
        .playing_o    (playing),
        .cur_lba_o    (cur_lba),
        .done_o       (done)
    );

    int vec = 0;
    int errs = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int   done_cnt = 0;
    int   req_cnt = 0;
    int   consec_viol = 0;
    bit   playing_seen = 0;
    logic wr_prev = 1'b0;
    logic req_prev = 1'b0;
    int   widx = 0;
    logic [15:0] prev_w = '0;

    // FIFO-side observer
    always @(negedge clk) begin
        if (cdda_wr === 1'b1) got_q.push_back(cdda_data);
        if (cdda_wr === 1'b1 && wr_prev === 1'b1) consec_viol++;
        if (done === 1'b1) done_cnt++;
        if (host_req === 1'b1 && req_prev !== 1'b1) req_cnt++;
        if (playing === 1'b1) playing_seen = 1;
        wr_prev = cdda_wr;
        req_prev = host_req;
    end

    function automatic logic [15:0] eff(input logic [15:0] w);
`ifdef CDDA_BYTESWAP_EN
        return byteswap ? {w[7:0], w[15:8]} : w;
`else
        return w;
`endif
    endfunction

    function automatic int frame_miss();
        int m = 0;
        if (got_q.size() != exp_q.size()) m++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        req_cnt = 0;
        consec_viol = 0;
        playing_seen = 0;
    endtask

    task automatic pulse_play(input logic [LW-1:0] s, input logic [LW-1:0] e);
        start_lba = s;
        end_lba = e;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_ack(output logic [LW-1:0] lba, output bit to);
        to = 1;
        lba = '0;
        for (int i = 0; i < 300; i++) begin
            if (host_req === 1'b1) begin
                to = 0;
                break;
            end
            tick();
        end
        if (!to) begin
            lba = host_lba;
            tick($urandom_range(0, 3));
            host_ack = 1'b1;
            tick();
            host_ack = 1'b0;
        end
        widx = 0;
    endtask

    task automatic send_one(input logic [15:0] w, input bit expect_push);
        host_data = w;
        host_wr = 1'b1;
        if (expect_push && widx[0]) exp_q.push_back({eff(w), eff(prev_w)});
        prev_w = w;
        widx++;
        tick();
    endtask

    task automatic send_words(input int n, input bit expect_push, input bit seq, input int maxgap);
        for (int i = 0; i < n; i++) begin
            send_one(seq ? 16'(widx) : 16'($urandom), expect_push);
            if (maxgap > 0) begin
                host_wr = 1'b0;
                tick($urandom_range(0, maxgap));
            end
        end
        host_wr = 1'b0;
        tick();
    endtask

    task automatic wait_idle(output bit to);
        to = 1;
        for (int i = 0; i < 300; i++) begin
            if (playing === 1'b0) begin
                to = 0;
                break;
            end
            tick();
        end
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        vec++; if (cdda_wr !== 1'b0) begin errs++; $display("FAIL reset_wr got %0h want 0", cdda_wr); end
        vec++; if (cdda_data !== 32'h0) begin errs++; $display("FAIL reset_data got %0h want 0", cdda_data); end
        vec++; if (host_req !== 1'b0) begin errs++; $display("FAIL reset_hreq got %0h want 0", host_req); end
        vec++; if (host_lba !== '0) begin errs++; $display("FAIL reset_hlba got %0h want 0", host_lba); end
        vec++; if (playing !== 1'b0) begin errs++; $display("FAIL reset_playing got %0h want 0", playing); end
        vec++; if (cur_lba !== '0) begin errs++; $display("FAIL reset_cur got %0h want 0", cur_lba); end
        vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %0h want 0", done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_play_range();
        logic [LW-1:0] lba;
        bit to;
        clear_mon();
        byteswap = 1'b0;
        cdda_req = 1'b1;
        pulse_play(24'd100, 24'd102);
        for (int s = 0; s < 2; s++) begin
            wait_ack(lba, to);
            vec++; if (to || lba !== 24'(100 + s)) begin errs++; $display("FAIL play_lba%0d got %0d want %0d to=%0d", s, lba, 100 + s, to); end
            send_words(SW, 1, 1, 0);
        end
        wait_idle(to);
        vec++; if (to) begin errs++; $display("FAIL play_idle timed out, want playing 0"); end
        vec++; if (req_cnt !== 2) begin errs++; $display("FAIL play_reqs got %0d want 2", req_cnt); end
        vec++; if (got_q.size() !== SW) begin errs++; $display("FAIL play_pushes got %0d want %0d", got_q.size(), SW); end
        vec++; if (got_q.size() == 0 || got_q[0] !== 32'h0001_0000) begin errs++; $display("FAIL play_first got %0h want 00010000", got_q.size() ? got_q[0] : 32'hx); end
        vec++; if (frame_miss() !== 0) begin errs++; $display("FAIL play_frames got %0d bad want 0", frame_miss()); end
        vec++; if (done_cnt !== 1) begin errs++; $display("FAIL play_done got %0d want 1", done_cnt); end
        vec++; if (cur_lba !== 24'd102) begin errs++; $display("FAIL play_cur got %0d want 102", cur_lba); end
    endtask

    task automatic test_flow_control();
        logic [LW-1:0] lba;
        bit to;
        clear_mon();
        cdda_req = 1'b1;
        byteswap = 1'($urandom);
        pulse_play(24'd200, 24'd203);
        wait_ack(lba, to);
        cdda_req = 1'b0;
        send_words(SW, 1, 0, 1);
        tick(50);
        vec++; if (host_req !== 1'b0 || req_cnt !== 1) begin errs++; $display("FAIL flow_hold got req=%0h cnt=%0d want 0/1", host_req, req_cnt); end
        cdda_req = 1'b1;
        for (int s = 1; s < 3; s++) begin
            wait_ack(lba, to);
            vec++; if (to || lba !== 24'(200 + s)) begin errs++; $display("FAIL flow_lba%0d got %0d want %0d to=%0d", s, lba, 200 + s, to); end
            send_words(SW, 1, 0, 1);
        end
        wait_idle(to);
        vec++; if (frame_miss() !== 0 || done_cnt !== 1) begin errs++; $display("FAIL flow_frames got bad=%0d done=%0d want 0/1", frame_miss(), done_cnt); end
        byteswap = 1'b0;
    endtask

    task automatic test_stop_restart();
        logic [LW-1:0] lba;
        bit to;
        clear_mon();
        cdda_req = 1'b1;
        pulse_play(24'd300, 24'd310);
        wait_ack(lba, to);
        send_words(300, 1, 0, 1);
        pulse_stop();
        send_words(SW - 300, 0, 0, 1);
        tick(40);
        vec++; if (got_q.size() !== 150 || frame_miss() !== 0) begin errs++; $display("FAIL stop_pushes got %0d bad=%0d want 150/0", got_q.size(), frame_miss()); end
        vec++; if (done_cnt !== 0 || playing !== 1'b0 || req_cnt !== 1) begin errs++; $display("FAIL stop_state got done=%0d play=%0h reqs=%0d want 0/0/1", done_cnt, playing, req_cnt); end
        clear_mon();
        pulse_play(24'd400, 24'd401);
        wait_ack(lba, to);
        vec++; if (to || lba !== 24'd400) begin errs++; $display("FAIL stop_replay got %0d want 400 to=%0d", lba, to); end
        send_words(SW, 1, 0, 1);
        wait_idle(to);
        vec++; if (frame_miss() !== 0 || done_cnt !== 1) begin errs++; $display("FAIL stop_replay_frames got bad=%0d done=%0d want 0/1", frame_miss(), done_cnt); end
        clear_mon();
        pulse_play(24'd600, 24'd602);
        wait_ack(lba, to);
        send_words(200, 1, 0, 1);
        pulse_play(24'd700, 24'd701);
        send_words(SW - 200, 0, 0, 1);
        wait_ack(lba, to);
        vec++; if (to || lba !== 24'd700) begin errs++; $display("FAIL restart_lba got %0d want 700 to=%0d", lba, to); end
        send_words(SW, 1, 0, 1);
        wait_idle(to);
        vec++; if (frame_miss() !== 0 || done_cnt !== 1 || req_cnt !== 2) begin errs++; $display("FAIL restart_frames got bad=%0d done=%0d reqs=%0d want 0/1/2", frame_miss(), done_cnt, req_cnt); end
    endtask

    task automatic test_empty_pause();
        logic [LW-1:0] lba;
        bit to;
        clear_mon();
        cdda_req = 1'b1;
        pulse_play(24'd5, 24'd5);
        tick(5);
        pulse_play(24'd9, 24'd3);
        tick(20);
        vec++; if (req_cnt !== 0 || done_cnt !== 2 || playing_seen !== 0) begin errs++; $display("FAIL empty_range got reqs=%0d done=%0d seen=%0d want 0/2/0", req_cnt, done_cnt, playing_seen); end
        clear_mon();
        pause = 1'b1;
        pulse_play(24'd20, 24'd22);
        tick(30);
        vec++; if (req_cnt !== 0 || playing !== 1'b1) begin errs++; $display("FAIL pause_hold got reqs=%0d play=%0h want 0/1", req_cnt, playing); end
        pause = 1'b0;
        wait_ack(lba, to);
        vec++; if (to || lba !== 24'd20) begin errs++; $display("FAIL pause_lba got %0d want 20 to=%0d", lba, to); end
        pause = 1'b1;
        send_words(SW, 1, 0, 1);
        tick(30);
        vec++; if (req_cnt !== 1 || frame_miss() !== 0) begin errs++; $display("FAIL pause_sector got reqs=%0d bad=%0d want 1/0", req_cnt, frame_miss()); end
        pause = 1'b0;
        wait_ack(lba, to);
        vec++; if (to || lba !== 24'd21) begin errs++; $display("FAIL pause_resume got %0d want 21 to=%0d", lba, to); end
        send_words(SW, 1, 0, 1);
        wait_idle(to);
        vec++; if (frame_miss() !== 0 || done_cnt !== 1) begin errs++; $display("FAIL pause_frames got bad=%0d done=%0d want 0/1", frame_miss(), done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] lba;
        bit to;
        clear_mon();
        cdda_req = 1'b1;
        pulse_play(24'd30, 24'd31);
        wait_ack(lba, to);
        send_words(SW, 1, 0, 0);
        wait_idle(to);
        vec++; if (consec_viol !== 0) begin errs++; $display("FAIL b2b_consec got %0d want 0", consec_viol); end
        vec++; if (frame_miss() !== 0 || done_cnt !== 1) begin errs++; $display("FAIL b2b_frames got bad=%0d done=%0d want 0/1", frame_miss(), done_cnt); end
        clear_mon();
        pulse_play(24'd800, 24'd810);
        wait_ack(lba, to);
        send_words(100, 1, 0, 0);
        host_wr = 1'b1;
        host_data = 16'($urandom);
        rst = 1'b1;
        tick();
        vec++; if ({cdda_wr, cdda_data, host_req, host_lba, playing, cur_lba, done} !== '0) begin errs++; $display("FAIL midreset_out got wr=%0h d=%0h hr=%0h hl=%0h p=%0h c=%0h dn=%0h want all 0", cdda_wr, cdda_data, host_req, host_lba, playing, cur_lba, done); end
        rst = 1'b0;
        tick(20);
        host_wr = 1'b0;
        tick(5);
        vec++; if (got_q.size() !== 50 || frame_miss() !== 0 || host_req !== 1'b0) begin errs++; $display("FAIL midreset_after got %0d bad=%0d hr=%0h want 50/0/0", got_q.size(), frame_miss(), host_req); end
    endtask

    task automatic test_byteswap();
        logic [LW-1:0] lba;
        logic [31:0] want;
        bit to;
        clear_mon();
        cdda_req = 1'b1;
        byteswap = 1'b1;
        pulse_play(24'd50, 24'd51);
        wait_ack(lba, to);
        send_one(16'h1234, 1);
        send_one(16'h5678, 1);
        send_words(SW - 2, 1, 0, 1);
        wait_idle(to);
`ifdef CDDA_BYTESWAP_EN
        want = 32'h7856_3412;
`else
        want = 32'h5678_1234;
`endif
        vec++; if (got_q.size() == 0 || got_q[0] !== want) begin errs++; $display("FAIL swap_first got %0h want %0h", got_q.size() ? got_q[0] : 32'hx, want); end
        vec++; if (frame_miss() !== 0 || done_cnt !== 1) begin errs++; $display("FAIL swap_frames got bad=%0d done=%0d want 0/1", frame_miss(), done_cnt); end
        byteswap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_play_range();
        test_flow_control();
        test_stop_restart();
        test_empty_pause();
        test_back_to_back();
        test_byteswap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
